// File: rtl/quantum_rr_scheduler.sv
// Round-robin preemptive scheduler: turns quantum expiry into a CPU
// preemption request, saves the preempted PC and dispatches the next ready pid.
module quantum_rr_scheduler #(
  parameter int NPROC = 8,
  parameter int PID_W = 3,
  parameter int PC_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_sigint,
  output logic             timer_reset,
  output logic             timer_stop,
  input  logic             create_valid,
  input  logic [PID_W-1:0] create_pid,
  input  logic [PC_W-1:0]  create_pc,
  input  logic             exit_valid,
  output logic             irq_req,
  input  logic             irq_ack,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic             load_pc_valid,
  output logic [PC_W-1:0]  load_pc,
  output logic [PID_W-1:0] current_pid,
  output logic             running
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DISPATCH,
    S_RUN,
    S_WAIT_ACK
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [NPROC-1:0] ready;
  logic [NPROC-1:0] ready_nx;
  logic [PC_W-1:0]  pc_tab [NPROC];
  logic [PID_W-1:0] cur;
  logic [PID_W-1:0] nxt_pid;
  logic [PID_W-1:0] idx;
  logic             found;
  logic [NPROC-1:0] cur_oh;
  logic             others;
  logic             irq_q;
  logic             irq_nx;
  logic             rearm_q;
  logic             rearm_nx;
  logic [PC_W-1:0]  lpc_q;
  logic             save_en;
  logic             clr_cur;
  logic             cre_ok;
  logic             run_st;

  assign run_st = (state == S_RUN) || (state == S_WAIT_ACK);
  assign cur_oh = {{(NPROC-1){1'b0}}, 1'b1} << cur;
  assign others = |(ready & ~cur_oh);

  assign cre_ok = create_valid && !ready[create_pid] &&
                  !(run_st && (create_pid == cur));

  // Scan far-to-near so the nearest ready pid after cur wins; cur is last.
  always_comb begin
    nxt_pid = cur;
    found   = 1'b0;
    idx     = cur;
    for (int i = NPROC; i >= 1; i--) begin
      idx = cur + PID_W'(i);
      if (ready[idx]) begin
        nxt_pid = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    irq_nx   = irq_q;
    rearm_nx = 1'b0;
    save_en  = 1'b0;
    clr_cur  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && |ready) state_nx = S_SELECT;
      end
      S_SELECT: begin
        state_nx = found ? S_DISPATCH : S_IDLE;
      end
      S_DISPATCH: begin
        state_nx = S_RUN;
      end
      S_RUN: begin
        if (exit_valid) begin
          clr_cur  = 1'b1;
          state_nx = S_SELECT;
        end else if (enable && tick_sigint) begin
          if (others) begin
            irq_nx   = 1'b1;
            state_nx = S_WAIT_ACK;
          end else begin
            // Single pulse even if the timer lags a cycle clearing tick.
            rearm_nx = ~rearm_q;
          end
        end
      end
      S_WAIT_ACK: begin
        if (exit_valid) begin
          clr_cur  = 1'b1;
          irq_nx   = 1'b0;
          state_nx = S_SELECT;
        end else if (irq_ack) begin
          save_en  = 1'b1;
          irq_nx   = 1'b0;
          state_nx = S_SELECT;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_nx = ready;
    if (clr_cur) ready_nx[cur] = 1'b0;
    if (cre_ok)  ready_nx[create_pid] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ready   <= '0;
      cur     <= '0;
      irq_q   <= 1'b0;
      rearm_q <= 1'b0;
      lpc_q   <= '0;
      for (int i = 0; i < NPROC; i++) pc_tab[i] <= '0;
    end else begin
      state   <= state_nx;
      ready   <= ready_nx;
      irq_q   <= irq_nx;
      rearm_q <= rearm_nx;
      if (state == S_SELECT && found) begin
        cur   <= nxt_pid;
        lpc_q <= pc_tab[nxt_pid];
      end
      if (save_en) pc_tab[cur] <= cpu_pc;
      if (cre_ok)  pc_tab[create_pid] <= create_pc;
    end
  end

  assign timer_reset   = reset | (state == S_DISPATCH) | rearm_q;
  assign timer_stop    = reset | ~run_st | ~enable;
  assign irq_req       = irq_q;
  assign load_pc_valid = (state == S_DISPATCH);
  assign load_pc       = lpc_q;
  assign current_pid   = cur;
  assign running       = run_st;

endmodule
